// File: rtl/mc_datapath_stall.sv
// mc_datapath_stall
// Multicycle MIPS-style datapath driven step by step by an external controller FSM.
// Holds PC, IR, MDR, A, B, ALUOut and the register file. A handshaked memory port may
// take several cycles; while a transfer is outstanding the datapath raises stall and
// freezes every architectural register. A transfer that never completes is ended after
// MEM_TIMEOUT cycles with read data forced to zero and a sticky bus_err flag.
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   pc_write, pc_write_cond    unconditional / ZERO-qualified PC load
//   IRwrite                    load IR from mem_rdata[31:0] on a read step
//   reg_dst, mem_to_reg        register write index (rt/rd/$31) and data (ALUOut/MDR/PC)
//   reg_write                  register file write enable
//   AluSrcA, AluSrcB, AluOp    ALU operand selects and operation
//   pc_src                     PC source (ALU, ALUOut, jump target, A)
//   IorD                       memory address source (PC or ALUOut)
//   mem_read, mem_write        memory request for this step
//   mem_addr, mem_wdata        memory address and write data (B)
//   mem_req, mem_we            request strobe and write qualifier
//   mem_ack, mem_rdata         transfer completion and read data
//   ZERO, opcode, func, stall  status returned to the controller
//   bus_err                    sticky memory timeout flag
//   cycle_cnt, instret_cnt     free-running cycle count and accepted instruction fetches
module mc_datapath_stall #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     NREGS       = 32,
    parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
    parameter int unsigned     MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            pc_write_cond,
    input  logic            IRwrite,
    input  logic [1:0]      reg_dst,
    input  logic [1:0]      mem_to_reg,
    input  logic            reg_write,
    input  logic            AluSrcA,
    input  logic [1:0]      AluSrcB,
    input  logic [2:0]      AluOp,
    input  logic [1:0]      pc_src,
    input  logic            IorD,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            ZERO,
    output logic [5:0]      opcode,
    output logic [5:0]      func,
    output logic            stall,
    output logic            bus_err,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
);

    localparam int unsigned     RIDX     = $clog2(NREGS);
    localparam int unsigned     WCW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [XLEN-1:0] XZERO    = {XLEN{1'b0}};
    localparam logic [WCW-1:0]  WCNT_ONE = WCW'(1);
    localparam logic [WCW-1:0]  WCNT_END = WCW'(MEM_TIMEOUT - 1);
    localparam logic [RIDX-1:0] RIDX_ZERO = {RIDX{1'b0}};

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_e;

    // architectural state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] aluout_q, aluout_d;
    logic [XLEN-1:0] regs_q [NREGS];

    // memory handshake state and counters
    mem_state_e      mstate_q, mstate_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic            bus_err_q, bus_err_d;
    logic [31:0]     cycle_q, cycle_d;
    logic [31:0]     instret_q, instret_d;

    // combinational helpers
    logic            mem_req_s;
    logic            timeout_done_s;
    logic            stall_s;
    logic            step_s;
    logic [XLEN-1:0] rdata_eff_s;
    logic [RIDX-1:0] rs_idx_s, rt_idx_s, rd_idx_s, wr_idx_s;
    logic [XLEN-1:0] rs_val_s, rt_val_s;
    logic [XLEN-1:0] imm_sext_s;
    logic [XLEN-1:0] alu_a_s, alu_b_s, alu_res_s;
    logic            zero_s;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] wr_data_s;
    logic            rf_we_s;
    logic            unused_s;

    assign mem_req_s = (mem_read | mem_write) & ~rst;
    // The final wait cycle completes the transfer on its own, so it is not a stall.
    assign timeout_done_s = mem_req_s & ~mem_ack & (mstate_q == M_WAIT) & (wcnt_q == WCNT_END);
    assign stall_s        = mem_req_s & ~mem_ack & ~timeout_done_s;
    assign step_s         = ~stall_s;
    assign rdata_eff_s    = timeout_done_s ? XZERO : mem_rdata;

    // Register indices use only the low log2(NREGS) bits of each field.
    assign rs_idx_s   = ir_q[21 +: RIDX];
    assign rt_idx_s   = ir_q[16 +: RIDX];
    assign rd_idx_s   = ir_q[11 +: RIDX];
    assign rs_val_s   = (rs_idx_s == RIDX_ZERO) ? XZERO : regs_q[rs_idx_s];
    assign rt_val_s   = (rt_idx_s == RIDX_ZERO) ? XZERO : regs_q[rt_idx_s];
    assign imm_sext_s = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

    // Instruction fields not consumed by the datapath (shamt and unused index bits).
    assign unused_s = ^ir_q;

    // ALU operand selection
    always_comb begin
        alu_a_s = AluSrcA ? a_q : pc_q;
        case (AluSrcB)
            2'd0:    alu_b_s = b_q;
            2'd1:    alu_b_s = {{(XLEN-3){1'b0}}, 3'b100};
            2'd2:    alu_b_s = imm_sext_s;
            2'd3:    alu_b_s = {imm_sext_s[XLEN-3:0], 2'b00};
            default: alu_b_s = b_q;
        endcase
    end

    // ALU operations; set-less-than results are zero-extended to the full width
    always_comb begin
        case (AluOp)
            3'b000:  alu_res_s = alu_a_s + alu_b_s;
            3'b001:  alu_res_s = alu_a_s - alu_b_s;
            3'b010:  alu_res_s = alu_a_s & alu_b_s;
            3'b011:  alu_res_s = alu_a_s | alu_b_s;
            3'b100:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
            3'b101:  alu_res_s = alu_a_s ^ alu_b_s;
            3'b110:  alu_res_s = ~(alu_a_s | alu_b_s);
            3'b111:  alu_res_s = {{(XLEN-1){1'b0}}, (alu_a_s < alu_b_s)};
            default: alu_res_s = XZERO;
        endcase
    end

    assign zero_s = (alu_res_s == XZERO);

    // PC source selection
    always_comb begin
        case (pc_src)
            2'd0:    pc_next_s = alu_res_s;
            2'd1:    pc_next_s = aluout_q;
            2'd2:    pc_next_s = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
            2'd3:    pc_next_s = a_q;
            default: pc_next_s = alu_res_s;
        endcase
    end

    // Register file write index and data selection
    always_comb begin
        case (reg_dst)
            2'd0:    wr_idx_s = rt_idx_s;
            2'd1:    wr_idx_s = rd_idx_s;
            2'd2:    wr_idx_s = {RIDX{1'b1}};
            default: wr_idx_s = rt_idx_s;
        endcase
        case (mem_to_reg)
            2'd0:    wr_data_s = aluout_q;
            2'd1:    wr_data_s = mdr_q;
            2'd2:    wr_data_s = pc_q;
            default: wr_data_s = aluout_q;
        endcase
    end

    // Writes to $0 are dropped so that it always reads as zero.
    assign rf_we_s = step_s & reg_write & (wr_idx_s != RIDX_ZERO);

    // Next-state of the architectural registers; everything holds on a stall cycle
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        aluout_d  = aluout_q;
        instret_d = instret_q;
        cycle_d   = cycle_q + 32'd1;
        if (step_s) begin
            a_d      = rs_val_s;
            b_d      = rt_val_s;
            aluout_d = alu_res_s;
            if (mem_read) begin
                mdr_d = rdata_eff_s;
            end else begin
                mdr_d = mdr_q;
            end
            if (IRwrite && mem_read) begin
                ir_d      = rdata_eff_s[31:0];
                instret_d = instret_q + 32'd1;
            end else begin
                ir_d      = ir_q;
                instret_d = instret_q;
            end
            if (pc_write || (pc_write_cond && zero_s)) begin
                pc_d = pc_next_s;
            end else begin
                pc_d = pc_q;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // Memory handshake next-state: wait counting, timeout and sticky bus error
    always_comb begin
        mstate_d  = mstate_q;
        wcnt_d    = wcnt_q;
        bus_err_d = bus_err_q;
        case (mstate_q)
            M_IDLE: begin
                if (mem_req_s && !mem_ack) begin
                    mstate_d = M_WAIT;
                    wcnt_d   = WCNT_ONE;
                end else begin
                    mstate_d = M_IDLE;
                    wcnt_d   = {WCW{1'b0}};
                end
            end
            M_WAIT: begin
                // A request withdrawn mid-wait is treated as abandoned.
                if (!mem_req_s || mem_ack) begin
                    mstate_d = M_IDLE;
                    wcnt_d   = {WCW{1'b0}};
                end else if (timeout_done_s) begin
                    mstate_d  = M_IDLE;
                    wcnt_d    = {WCW{1'b0}};
                    bus_err_d = 1'b1;
                end else begin
                    mstate_d = M_WAIT;
                    wcnt_d   = wcnt_q + WCNT_ONE;
                end
            end
            default: begin
                mstate_d = M_IDLE;
                wcnt_d   = {WCW{1'b0}};
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            mdr_q     <= XZERO;
            a_q       <= XZERO;
            b_q       <= XZERO;
            aluout_q  <= XZERO;
            mstate_q  <= M_IDLE;
            wcnt_q    <= {WCW{1'b0}};
            bus_err_q <= 1'b0;
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            aluout_q  <= aluout_d;
            mstate_q  <= mstate_d;
            wcnt_q    <= wcnt_d;
            bus_err_q <= bus_err_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Register file storage; reads of a register written this step see the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= XZERO;
            end
        end else if (rf_we_s) begin
            regs_q[wr_idx_s] <= wr_data_s;
        end
    end

    assign mem_addr    = IorD ? aluout_q : pc_q;
    assign mem_wdata   = b_q;
    assign mem_req     = mem_req_s;
    assign mem_we      = mem_write;
    assign ZERO        = zero_s;
    assign opcode      = ir_q[31:26];
    assign func        = ir_q[5:0];
    assign stall       = stall_s;
    assign bus_err     = bus_err_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_mc_datapath_stall.sv
module tb_mc_datapath_stall;

    localparam int          TO     = 16;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0, pc_write_cond = 1'b0, IRwrite = 1'b0, reg_write = 1'b0;
    logic [1:0]  reg_dst = 2'd0, mem_to_reg = 2'd0, AluSrcB = 2'd0, pc_src = 2'd0;
    logic        AluSrcA = 1'b0, IorD = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_ack = 1'b0;
    logic [2:0]  AluOp = 3'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] mem_addr, mem_wdata, cycle_cnt, instret_cnt;
    logic        mem_req, mem_we, ZERO, stall, bus_err;
    logic [5:0]  opcode, func;

    mc_datapath_stall #(.XLEN(32), .NREGS(32), .RESET_PC(RST_PC), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .IRwrite(IRwrite), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .pc_src(pc_src), .IorD(IorD),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ZERO(ZERO), .opcode(opcode), .func(func), .stall(stall), .bus_err(bus_err),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, irw, rw, sa, iord, mr, mw;
        logic [1:0] rdst, m2r, sb, ps;
        logic [2:0] op;
    } ctl_t;

    typedef struct {
        logic [31:0] addr, wdata, instret, cyc;
        logic [5:0]  opc, fn;
        logic        zero, req, berr;
        int          stalls;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_mis = 0;

    // reference machine state
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alo, m_instret;
    logic [31:0] m_regs [32];
    logic        m_berr;
    int          m_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x; sy = y;
        case (op)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return (sx < sy) ? 32'd1 : 32'd0;
            3'd5: return x ^ y;
            3'd6: return ~(x | y);
            3'd7: return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic apply(input ctl_t c);
        pc_write = c.pcw; pc_write_cond = c.pcwc; IRwrite = c.irw; reg_write = c.rw;
        AluSrcA = c.sa; IorD = c.iord; mem_read = c.mr; mem_write = c.mw;
        reg_dst = c.rdst; mem_to_reg = c.m2r; AluSrcB = c.sb; pc_src = c.ps; AluOp = c.op;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ir = 32'd0; m_mdr = 32'd0; m_a = 32'd0; m_b = 32'd0; m_alo = 32'd0;
        m_instret = 32'd0; m_berr = 1'b0; m_cycles = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // One controller step: queue the expected observation, drive it, then advance the model.
    task automatic do_step(input ctl_t c, input int lat, input logic [31:0] rd);
        exp_t e;
        int stalls;
        bit req, tmo;
        logic [31:0] opa, opb, imm, res, rdv, wd, npc;
        logic [4:0] idx;
        req = c.mr | c.mw;
        if (!req) begin stalls = 0; tmo = 0; end
        else if (lat >= TO) begin stalls = TO - 1; tmo = 1; end
        else begin stalls = lat; tmo = 0; end
        imm = {{16{m_ir[15]}}, m_ir[15:0]};
        opa = c.sa ? m_a : m_pc;
        case (c.sb)
            2'd0: opb = m_b;
            2'd1: opb = 32'd4;
            2'd2: opb = imm;
            default: opb = imm * 4;
        endcase
        res = alu(c.op, opa, opb);
        e.addr = c.iord ? m_alo : m_pc;
        e.wdata = m_b; e.opc = m_ir[31:26]; e.fn = m_ir[5:0];
        e.zero = (res == 32'd0); e.req = req; e.berr = m_berr;
        e.instret = m_instret; e.cyc = m_cycles + stalls; e.stalls = stalls;
        q.push_back(e);
        apply(c);
        mem_rdata = rd;
        for (int k = 0; k <= stalls; k++) begin
            mem_ack = req && (k == lat);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        m_cycles += stalls + 1;
        // architectural update, all from pre-step values
        rdv = tmo ? 32'd0 : rd;
        case (c.ps)
            2'd0: npc = res;
            2'd1: npc = m_alo;
            2'd2: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
            default: npc = m_a;
        endcase
        idx = (c.rdst == 2'd0) ? m_ir[20:16] : (c.rdst == 2'd1) ? m_ir[15:11] : 5'd31;
        wd  = (c.m2r == 2'd0) ? m_alo : (c.m2r == 2'd1) ? m_mdr : m_pc;
        m_a = m_regs[m_ir[25:21]];
        m_b = m_regs[m_ir[20:16]];
        if (c.rw && idx != 5'd0) m_regs[idx] = wd;
        m_alo = res;
        if (c.mr) m_mdr = rdv;
        if (c.pcw || (c.pcwc && res == 32'd0)) m_pc = npc;
        if (c.irw && c.mr) begin m_ir = rdv; m_instret = m_instret + 32'd1; end
        if (tmo) m_berr = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] instr, input int lat);
        ctl_t c = '0;
        c.mr = 1'b1; c.irw = 1'b1; c.sb = 2'd1; c.pcw = 1'b1;
        do_step(c, lat, instr);
    endtask

    task automatic nop_step();
        ctl_t c = '0;
        do_step(c, 0, 32'd0);
    endtask

    // addi-style sequence: fetch, decode, execute, write back into rt
    task automatic addi(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        ctl_t c;
        fetch(itype(6'h08, rs, rt, imm), 0);
        nop_step();
        c = '0; c.sa = 1'b1; c.sb = 2'd2;
        do_step(c, 0, 32'd0);
        c = '0; c.rw = 1'b1;
        do_step(c, 0, 32'd0);
    endtask

    task automatic beq(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] off);
        ctl_t c;
        fetch(itype(6'h04, rs, rt, off), 1);
        c = '0; c.sb = 2'd3;
        do_step(c, 0, 32'd0);
        c = '0; c.sa = 1'b1; c.op = 3'd1; c.pcwc = 1'b1; c.ps = 2'd1;
        do_step(c, 0, 32'd0);
    endtask

    task automatic do_reset();
        ctl_t c = '0;
        apply(c);
        mem_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Scoreboard monitor: one expected entry per step, compared on the cycle the step completes.
    int scnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                if (stall) begin
                    scnt++;
                end else begin
                    e = q.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wdata", mem_wdata, e.wdata);
                    chk("opcode", {26'd0, opcode}, {26'd0, e.opc});
                    chk("func", {26'd0, func}, {26'd0, e.fn});
                    chk("zero", {31'd0, ZERO}, {31'd0, e.zero});
                    chk("mem_req", {31'd0, mem_req}, {31'd0, e.req});
                    chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                    chk("instret", instret_cnt, e.instret);
                    chk("cycle_cnt", cycle_cnt, e.cyc);
                    chk("stall_cycles", scnt, e.stalls);
                    scnt = 0;
                end
            end
        end
    end

    initial begin
        ctl_t c;
        int lat;
        logic [31:0] rd;

        do_reset();
        #3;
        chk("rst_pc", mem_addr, RST_PC);
        chk("rst_ir", {26'd0, opcode}, 32'd0);
        chk("rst_b", mem_wdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_berr", {31'd0, bus_err}, 32'd0);
        chk("rst_cycle", cycle_cnt, 32'd0);
        chk("rst_instret", instret_cnt, 32'd0);
        @(posedge clk); #1;
        m_cycles++;

        // zero-wait fetch
        fetch(32'h8C22_0010, 0);
        c = '0; apply(c); #1;
        chk("fetch0_pc", mem_addr, RST_PC + 32'd4);
        chk("fetch0_opc", {26'd0, opcode}, 32'h23);
        chk("fetch0_instret", instret_cnt, 32'd1);
        // fetch with three wait cycles
        fetch(32'h0000_002A, 3);

        // beq taken then not taken
        addi(5'd0, 5'd1, 16'd5);
        addi(5'd0, 5'd2, 16'd5);
        beq(5'd1, 5'd2, 16'd3);
        addi(5'd0, 5'd2, 16'd6);
        beq(5'd1, 5'd2, 16'd3);

        // $0 stays zero: MDR=0xDEAD written to rt=0
        fetch(itype(6'h23, 5'd0, 5'd0, 16'd0), 0);
        c = '0; c.iord = 1'b1; c.mr = 1'b1;
        do_step(c, 2, 32'h0000_DEAD);
        c = '0; c.rw = 1'b1; c.m2r = 2'd1;
        do_step(c, 0, 32'd0);
        fetch(itype(6'h2B, 5'd0, 5'd0, 16'd0), 0);
        nop_step();
        c = '0; apply(c); #1;
        chk("r0_reads_zero", mem_wdata, 32'd0);

        // jal: R31 <= PC, PC <= jump target
        fetch({6'h03, 26'h000_0040}, 0);
        c = '0; c.rw = 1'b1; c.rdst = 2'd2; c.m2r = 2'd2; c.pcw = 1'b1; c.ps = 2'd2;
        do_step(c, 0, 32'd0);
        c = '0; apply(c); #1;
        chk("jal_target", mem_addr, 32'h0000_0100);
        fetch(itype(6'h2B, 5'd0, 5'd31, 16'd0), 0);
        nop_step();
        nop_step();

        // randomized control sequences
        for (int n = 0; n < 300; n++) begin
            c = '0;
            c.pcw = ($urandom_range(0, 3) == 0);
            c.pcwc = ($urandom_range(0, 3) == 0);
            c.rw = ($urandom_range(0, 1) == 1);
            c.sa = $urandom_range(0, 1);
            c.iord = $urandom_range(0, 1);
            c.rdst = $urandom_range(0, 2);
            c.m2r = $urandom_range(0, 2);
            c.sb = $urandom_range(0, 3);
            c.ps = $urandom_range(0, 3);
            c.op = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: ;
                1: c.mr = 1'b1;
                2: c.mw = 1'b1;
                default: begin c.mr = 1'b1; c.irw = 1'b1; end
            endcase
            lat = ($urandom_range(0, 39) == 0) ? 20 : $urandom_range(0, 4);
            rd = $urandom;
            do_step(c, lat, rd);
        end

        // timeout: no ack at all
        fetch(32'h1234_5678, 0);
        fetch(32'hFFFF_FFFF, 40);
        c = '0; apply(c); #1;
        chk("tmo_berr", {31'd0, bus_err}, 32'd1);
        chk("tmo_ir_zero", {20'd0, opcode, func}, 32'd0);
        nop_step();
        nop_step();

        // reset while waiting in M_WAIT
        c = '0; c.mr = 1'b1; c.irw = 1'b1; c.sb = 2'd1; c.pcw = 1'b1;
        apply(c);
        mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstwait_req_low", {31'd0, mem_req}, 32'd0);
        chk("rstwait_no_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("rstwait_pc", mem_addr, RST_PC);
        chk("rstwait_cycle", cycle_cnt, 32'd0);
        chk("rstwait_instret", instret_cnt, 32'd0);
        chk("rstwait_berr", {31'd0, bus_err}, 32'd0);
        rst = 1'b0;
        c = '0; apply(c);
        model_reset();
        fetch(32'h2001_0007, 0);
        fetch(32'h2002_0009, 2);
        nop_step();

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "time bound");
    end

endmodule
